// File: rtl/hsv_core_decode_pkg.sv
// Shared types for the decode sequencer: fetch beat payload, instruction formats,
// major opcode encodings and sequencer FSM states.
package hsv_core_decode_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OPC_W = 5;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_increment;
        logic [XLEN-1:0] insn;
    } fetch_data_t;

    typedef enum logic [2:0] {
        FMT_R       = 3'd0,
        FMT_I       = 3'd1,
        FMT_S       = 3'd2,
        FMT_B       = 3'd3,
        FMT_U       = 3'd4,
        FMT_J       = 3'd5,
        FMT_ILLEGAL = 3'd6
    } insn_format_t;

    typedef enum logic {
        SEQ_RUN  = 1'b0,
        SEQ_HALT = 1'b1
    } decode_seq_state_t;

    // Major opcode field insn[6:2]
    localparam logic [OPC_W-1:0] OPC_LOAD     = 5'b00000;
    localparam logic [OPC_W-1:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [OPC_W-1:0] OPC_AUIPC    = 5'b00101;
    localparam logic [OPC_W-1:0] OPC_STORE    = 5'b01000;
    localparam logic [OPC_W-1:0] OPC_OP       = 5'b01100;
    localparam logic [OPC_W-1:0] OPC_LUI      = 5'b01101;
    localparam logic [OPC_W-1:0] OPC_BRANCH   = 5'b11000;
    localparam logic [OPC_W-1:0] OPC_JALR     = 5'b11001;
    localparam logic [OPC_W-1:0] OPC_JAL      = 5'b11011;
    localparam logic [OPC_W-1:0] OPC_SYSTEM   = 5'b11100;

    // Opcodes whose side effects require the front end to stop until redirected
    function automatic logic is_serializing_opcode(input logic [OPC_W-1:0] opc);
        return (opc == OPC_SYSTEM) || (opc == OPC_MISC_MEM);
    endfunction

endpackage

// File: rtl/hsv_core_decode_format.sv
// Combinational instruction format classifier; only the low seven insn bits matter.
module hsv_core_decode_format
    import hsv_core_decode_pkg::*;
(
    input  logic [6:0]   i_insn_low,
    output insn_format_t o_format_c,
    output logic         o_serialize_c
);

    logic [OPC_W-1:0] w_opc;
    logic             w_full_width;

    assign w_opc        = i_insn_low[6:2];
    assign w_full_width = (i_insn_low[1:0] == 2'b11);

    always_comb begin
        o_format_c    = FMT_ILLEGAL;
        o_serialize_c = 1'b0;
        if (w_full_width) begin
            unique case (w_opc)
                OPC_OP:                                   o_format_c = FMT_R;
                OPC_OP_IMM, OPC_LOAD, OPC_JALR,
                OPC_SYSTEM, OPC_MISC_MEM:                 o_format_c = FMT_I;
                OPC_STORE:                                o_format_c = FMT_S;
                OPC_BRANCH:                               o_format_c = FMT_B;
                OPC_LUI, OPC_AUIPC:                       o_format_c = FMT_U;
                OPC_JAL:                                  o_format_c = FMT_J;
                default:                                  o_format_c = FMT_ILLEGAL;
            endcase
        end
        // Illegal encodings are serialized so the trap path sees a quiet pipeline
        o_serialize_c = (o_format_c == FMT_ILLEGAL)
                     || (w_full_width && is_serializing_opcode(w_opc));
    end

endmodule

// File: rtl/hsv_core_decode_sequencer.sv
// Decode-stage sequencer: buffers fetch beats with their format, presents the head to issue,
// and halts intake after a serializing instruction until the next flush.
module hsv_core_decode_sequencer
    import hsv_core_decode_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_core,
    input  logic             rst_core,
    input  logic             flush,
    input  logic             fetch_valid,
    output logic             fetch_ready,
    input  fetch_data_t      fetch_data,
    output logic             out_valid,
    input  logic             out_ready,
    output fetch_data_t      out_data,
    output insn_format_t     out_format,
    output logic             out_serialize,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned COUNT_W  = PTR_W + 1;
    localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(DEPTH);

    decode_seq_state_t r_state;
    decode_seq_state_t w_state_next;

    fetch_data_t       r_buf_data [DEPTH];
    insn_format_t      r_buf_fmt  [DEPTH];
    logic              r_buf_ser  [DEPTH];

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [COUNT_W-1:0] r_count;
    logic [CNT_W-1:0]  r_stall;

    insn_format_t      w_new_fmt;
    logic              w_new_ser;
    logic              w_fetch_ready;
    logic              w_push;
    logic              w_pop;

    hsv_core_decode_format u_format (
        .i_insn_low    (fetch_data.insn[6:0]),
        .o_format_c    (w_new_fmt),
        .o_serialize_c (w_new_ser)
    );

    // FSM state register
    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            r_state <= SEQ_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and intake readiness; flush always returns to RUN and blocks intake
    always_comb begin
        w_state_next  = r_state;
        w_fetch_ready = 1'b0;
        unique case (r_state)
            SEQ_RUN: begin
                w_fetch_ready = !rst_core && (r_count < FULL_COUNT) && !flush;
                if (fetch_valid && w_fetch_ready && w_new_ser) begin
                    w_state_next = SEQ_HALT;
                end
            end
            SEQ_HALT: begin
                w_fetch_ready = 1'b0;
            end
            default: begin
                w_state_next = SEQ_RUN;
            end
        endcase
        if (flush) begin
            w_state_next = SEQ_RUN;
        end
    end

    assign fetch_ready = w_fetch_ready;
    assign w_push      = fetch_valid && fetch_ready;
    assign w_pop       = out_valid && out_ready;

    // Per-entry storage; format is captured at push so the head never re-decodes
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        always_ff @(posedge clk_core or posedge rst_core) begin
            if (rst_core) begin
                r_buf_data[g] <= '0;
                r_buf_fmt[g]  <= FMT_ILLEGAL;
                r_buf_ser[g]  <= 1'b0;
            end else if (w_push && (r_wr_ptr == PTR_W'(g))) begin
                r_buf_data[g] <= fetch_data;
                r_buf_fmt[g]  <= w_new_fmt;
                r_buf_ser[g]  <= w_new_ser;
            end
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + COUNT_W'(1);
                2'b01:   r_count <= r_count - COUNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Backpressure counter, saturating; survives flush
    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            r_stall <= '0;
        end else if (out_valid && !out_ready && !flush && (r_stall != '1)) begin
            r_stall <= r_stall + CNT_W'(1);
        end
    end

    assign out_valid     = (r_count != '0);
    assign out_data      = r_buf_data[r_rd_ptr];
    assign out_format    = r_buf_fmt[r_rd_ptr];
    assign out_serialize = r_buf_ser[r_rd_ptr];
    assign halted        = (r_state == SEQ_HALT);
    assign stall_cycles  = r_stall;

endmodule

// File: tb/tb_hsv_core_decode_sequencer.sv
// Bench for the decode sequencer: directed scenarios then random traffic, all checked
// against a queue-based reference model of the stage.
module tb_hsv_core_decode_sequencer;
    import hsv_core_decode_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 32;

    logic             clk_core = 1'b0;
    logic             rst_core;
    logic             flush;
    logic             fetch_valid;
    logic             fetch_ready;
    fetch_data_t      fetch_data;
    logic             out_valid;
    logic             out_ready;
    fetch_data_t      out_data;
    insn_format_t     out_format;
    logic             out_serialize;
    logic             halted;
    logic [CNT_W-1:0] stall_cycles;

    hsv_core_decode_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_core      (clk_core),
        .rst_core      (rst_core),
        .flush         (flush),
        .fetch_valid   (fetch_valid),
        .fetch_ready   (fetch_ready),
        .fetch_data    (fetch_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_format    (out_format),
        .out_serialize (out_serialize),
        .halted        (halted),
        .stall_cycles  (stall_cycles)
    );

    always #5 clk_core = ~clk_core;

    typedef struct {
        fetch_data_t d;
        logic [2:0]  f;
        logic        s;
    } ent_t;

    ent_t             m_q[$];
    logic             m_halt;
    logic [CNT_W-1:0] m_stall;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [31:0] rnd;
    logic [31:0] ins;
    logic [31:0] pcv;
    logic [6:0]  opc_tab [15];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ISA-level classification by full 7-bit opcode
    function automatic ent_t ref_entry(input fetch_data_t d);
        ent_t e;
        e.d = d;
        e.s = 1'b0;
        case (d.insn[6:0])
            7'h33:                      e.f = 3'(FMT_R);
            7'h13, 7'h03, 7'h67:        e.f = 3'(FMT_I);
            7'h73, 7'h0F: begin         e.f = 3'(FMT_I); e.s = 1'b1; end
            7'h23:                      e.f = 3'(FMT_S);
            7'h63:                      e.f = 3'(FMT_B);
            7'h37, 7'h17:               e.f = 3'(FMT_U);
            7'h6F:                      e.f = 3'(FMT_J);
            default: begin              e.f = 3'(FMT_ILLEGAL); e.s = 1'b1; end
        endcase
        return e;
    endfunction

    function automatic fetch_data_t mkfd(input logic [31:0] pc, input logic [31:0] insn);
        fetch_data_t d;
        d.pc           = pc;
        d.pc_increment = pc + 32'd4;
        d.insn         = insn;
        return d;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_halt  = 1'b0;
        m_stall = '0;
    endtask

    task automatic check_model(input logic fl);
        logic exp_ready;
        exp_ready = !m_halt && (m_q.size() < DEPTH) && !fl;
        chk("fetch_ready", 128'(fetch_ready), 128'(exp_ready));
        chk("out_valid", 128'(out_valid), 128'(m_q.size() != 0));
        chk("halted", 128'(halted), 128'(m_halt));
        chk("stall_cycles", 128'(stall_cycles), 128'(m_stall));
        if (m_q.size() != 0) begin
            chk("out_data", 128'(out_data), 128'(m_q[0].d));
            chk("out_format", 128'(out_format), 128'(m_q[0].f));
            chk("out_serialize", 128'(out_serialize), 128'(m_q[0].s));
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_fetch_ready"}, 128'(fetch_ready), 128'(0));
        chk({tag, "_out_valid"}, 128'(out_valid), 128'(0));
        chk({tag, "_out_data"}, 128'(out_data), 128'(0));
        chk({tag, "_out_format"}, 128'(out_format), 128'(FMT_ILLEGAL));
        chk({tag, "_out_serialize"}, 128'(out_serialize), 128'(0));
        chk({tag, "_halted"}, 128'(halted), 128'(0));
        chk({tag, "_stall"}, 128'(stall_cycles), 128'(0));
    endtask

    // One clock cycle: drive at negedge, check before the edge, advance the model at the edge
    task automatic cycle(input logic fv, input fetch_data_t fd, input logic ordy, input logic fl);
        logic do_push;
        logic do_pop;
        logic had_head;
        ent_t e;
        fetch_valid = fv;
        fetch_data  = fd;
        out_ready   = ordy;
        flush       = fl;
        #1;
        check_model(fl);
        had_head = (m_q.size() != 0);
        do_push  = fv && !m_halt && (m_q.size() < DEPTH) && !fl;
        do_pop   = had_head && ordy;
        e        = ref_entry(fd);
        @(posedge clk_core);
        if (had_head && !ordy && !fl && (m_stall != '1)) m_stall = m_stall + 1;
        if (fl) begin
            m_q.delete();
            m_halt = 1'b0;
        end else begin
            if (do_pop) void'(m_q.pop_front());
            if (do_push) begin
                m_q.push_back(e);
                if (e.s) m_halt = 1'b1;
            end
        end
        @(negedge clk_core);
    endtask

    initial begin
        opc_tab = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63,
                    7'h37, 7'h17, 7'h6F, 7'h00, 7'h7F, 7'h2B, 7'h53};
        rst_core    = 1'b1;
        flush       = 1'b0;
        fetch_valid = 1'b0;
        out_ready   = 1'b0;
        fetch_data  = '0;
        model_reset();
        repeat (2) @(negedge clk_core);
        check_reset_vals("reset");
        rst_core = 1'b0;
        #1;
        chk("post_reset_ready", 128'(fetch_ready), 128'(1));

        // Single ADD through an empty buffer
        cycle(1'b1, mkfd(32'h100, 32'h003100B3), 1'b1, 1'b0);
        chk("t1_valid", 128'(out_valid), 128'(1));
        chk("t1_fmt", 128'(out_format), 128'(FMT_R));
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("t1_drained", 128'(out_valid), 128'(0));

        // Backpressure: three offers, two accepted
        cycle(1'b1, mkfd(32'h100, 32'h003100B3), 1'b0, 1'b0);
        cycle(1'b1, mkfd(32'h104, 32'h00100093), 1'b0, 1'b0);
        cycle(1'b1, mkfd(32'h108, 32'h00200113), 1'b0, 1'b0);
        chk("t2_full_ready", 128'(fetch_ready), 128'(0));
        chk("t2_head_pc0", 128'(out_data.pc), 128'(32'h100));
        chk("t2_stall", 128'(stall_cycles), 128'(2));
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("t2_head_pc1", 128'(out_data.pc), 128'(32'h104));
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("t2_empty", 128'(out_valid), 128'(0));

        // Format coverage
        cycle(1'b1, mkfd(32'h200, 32'h000010B7), 1'b1, 1'b0);
        chk("t3_lui", 128'(out_format), 128'(FMT_U));
        cycle(1'b1, mkfd(32'h204, 32'h0000006F), 1'b1, 1'b0);
        chk("t3_jal", 128'(out_format), 128'(FMT_J));
        cycle(1'b1, mkfd(32'h208, 32'h0020A023), 1'b1, 1'b0);
        chk("t3_sw", 128'(out_format), 128'(FMT_S));
        cycle(1'b1, mkfd(32'h20C, 32'h00208063), 1'b1, 1'b0);
        chk("t3_beq", 128'(out_format), 128'(FMT_B));
        cycle(1'b0, '0, 1'b1, 1'b0);

        // ECALL halts intake until flush
        cycle(1'b1, mkfd(32'h300, 32'h00000073), 1'b0, 1'b0);
        chk("t4_halted", 128'(halted), 128'(1));
        cycle(1'b1, mkfd(32'h304, 32'h00100093), 1'b0, 1'b0);
        chk("t4_ready_low", 128'(fetch_ready), 128'(0));
        chk("t4_ecall_ser", 128'(out_serialize), 128'(1));
        cycle(1'b1, mkfd(32'h304, 32'h00100093), 1'b1, 1'b0);
        chk("t4_drained", 128'(out_valid), 128'(0));
        cycle(1'b1, mkfd(32'h304, 32'h00100093), 1'b1, 1'b0);
        chk("t4_still_empty", 128'(out_valid), 128'(0));
        cycle(1'b0, '0, 1'b0, 1'b1);
        flush = 1'b0;
        #1;
        chk("t4_unhalted", 128'(halted), 128'(0));
        chk("t4_ready", 128'(fetch_ready), 128'(1));
        @(negedge clk_core);

        // Flush on a full buffer drops the offered beat
        cycle(1'b1, mkfd(32'h400, 32'h003100B3), 1'b0, 1'b0);
        cycle(1'b1, mkfd(32'h404, 32'h003100B3), 1'b0, 1'b0);
        cycle(1'b1, mkfd(32'h408, 32'h003100B3), 1'b1, 1'b1);
        chk("t5_flushed", 128'(out_valid), 128'(0));
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Illegal encodings serialize
        cycle(1'b1, mkfd(32'h500, 32'h00000000), 1'b0, 1'b0);
        chk("t6_zero_fmt", 128'(out_format), 128'(FMT_ILLEGAL));
        chk("t6_zero_ser", 128'(out_serialize), 128'(1));
        chk("t6_zero_halt", 128'(halted), 128'(1));
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b1, mkfd(32'h504, 32'hFFFFFFFF), 1'b0, 1'b0);
        chk("t6_ones_fmt", 128'(out_format), 128'(FMT_ILLEGAL));
        chk("t6_ones_halt", 128'(halted), 128'(1));
        cycle(1'b0, '0, 1'b0, 1'b0);

        // Asynchronous reset mid-stream
        #2;
        rst_core = 1'b1;
        #1;
        check_reset_vals("midrst");
        model_reset();
        @(negedge clk_core);
        rst_core = 1'b0;

        // Random traffic
        pcv = 32'h1000;
        for (int i = 0; i < 400; i++) begin
            rnd = $urandom();
            ins = {rnd[31:7], opc_tab[$urandom_range(0, 14)]};
            cycle($urandom_range(0, 3) != 0, mkfd(pcv, ins),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 11) == 0);
            pcv = pcv + 32'd4;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
